// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills the instruction RAM and holds the core in reset
//
// Purpose:
//   Receives a header-framed, little-endian byte stream. The first two bytes
//   give the word count N. The next N*4 bytes are packed into 32-bit
//   instruction words. Each word is issued as a single-cycle write to a
//   writable instruction RAM. The processor is held in reset for the whole
//   load and is released once the last word has been written.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       1-cycle pulse, begins a load (honoured in IDLE/DONE/ERR only)
//   byte_valid  byte_data is valid this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte (transfer = byte_valid && byte_ready)
//   mem_we      instruction-memory write strobe, one cycle per word
//   mem_addr    byte address of the write (word_idx*4), registered
//   mem_wdata   assembled instruction word, registered
//   cpu_hold    1 = keep the processor in reset
//   busy        load in progress (HDR0..WRITE)
//   done        sticky, last load completed
//   err         sticky, last load rejected (bad word count)

module imem_loader #(
  parameter int DEPTH  = 18,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          IDX_W   = $clog2(DEPTH + 1);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]       state;
  logic [15:0]      cnt;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  // Lanes 0..2 of the word being assembled; lane 3 goes straight to mem_wdata.
  logic [23:0]      word_lo;

  logic        xfer;
  logic        start_ok;
  logic [15:0] cnt_full;
  logic [15:0] idx_next16;

  // All status outputs are decoded from the state register. A reset therefore
  // drives them to their idle values asynchronously, with no clock needed.
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_HDR0, S_HDR1, S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      // A rejected load keeps the core held, so no partial program can run.
      S_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign xfer       = byte_valid && byte_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign cnt_full   = {byte_data, cnt[7:0]};
  // Compare the next word index against N at full 16-bit width, so a large
  // count is never aliased by truncation.
  assign idx_next16 = 16'(word_idx) + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word_lo   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_ok) begin
            state    <= S_HDR0;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end

        S_HDR0: begin
          if (xfer) begin
            cnt[7:0] <= byte_data;
            state    <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (xfer) begin
            cnt[15:8] <= byte_data;
            if ((cnt_full == 16'd0) || (cnt_full > DEPTH16)) begin
              state <= S_ERR;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= byte_data;
              2'd1: word_lo[15:8]  <= byte_data;
              2'd2: word_lo[23:16] <= byte_data;
              default: begin
                // Register the address and data now, so both are stable
                // for the whole cycle in which mem_we is high.
                mem_wdata <= {byte_data, word_lo};
                mem_addr  <= ADDR_W'({word_idx, 2'b00});
                state     <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (idx_next16 == cnt) begin
            state <= S_DONE;
          end else begin
            state <= S_DATA;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  int          nw;
  int          lat_bad;
  int          width_bad;
  logic        prev_we;
  logic        prev_xfer;
  logic [7:0]  q [$];

  imem_loader #(.DEPTH(18), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log plus strobe-shape checks, sampled 1 time unit after the falling edge.
  always @(negedge clk) begin
    #1;
    if (mem_we) begin
      if (nw < 64) begin
        wa[nw] = mem_addr;
        wd[nw] = mem_wdata;
      end
      nw = nw + 1;
      if (!prev_xfer) lat_bad = lat_bad + 1;
      if (prev_we) width_bad = width_bad + 1;
    end
    prev_we   = mem_we;
    prev_xfer = byte_valid && byte_ready;
  end

  task automatic clear_log();
    nw        = 0;
    lat_bad   = 0;
    width_bad = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL byte_accept_timeout: byte_ready stayed %0b for 100 cycles, want 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_q(input int maxgap);
    foreach (q[i]) send_byte(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    q.delete();
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s_end_timeout: done=%0b err=%0b, want one of them 1", tag, done, err);
    end
    #2;
  endtask

  task automatic check_basic_writes(input string tag);
    vectors++;
    if (nw !== 2) begin
      miscompares++;
      $display("FAIL %s_write_count: got %0d want 2", tag, nw);
    end
    vectors++;
    if (wa[0] !== 32'h0 || wd[0] !== 32'hFF600293) begin
      miscompares++;
      $display("FAIL %s_word0: got %h@%h want ff600293@00000000", tag, wd[0], wa[0]);
    end
    vectors++;
    if (wa[1] !== 32'h4 || wd[1] !== 32'h00528333) begin
      miscompares++;
      $display("FAIL %s_word1: got %h@%h want 00528333@00000004", tag, wd[1], wa[1]);
    end
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_final: got done=%0b hold=%0b busy=%0b err=%0b want 1 0 0 0", tag, done, cpu_hold, busy, err);
    end
    vectors++;
    if (lat_bad !== 0 || width_bad !== 0) begin
      miscompares++;
      $display("FAIL %s_strobe: got late=%0d wide=%0d want 0 0", tag, lat_bad, width_bad);
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%0b we=%0b hold=%0b busy=%0b done=%0b err=%0b addr=%h data=%h want all 0",
               byte_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rdy=%0b hold=%0b want 0 0", byte_ready, cpu_hold);
    end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    vectors++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_loading: got hold=%0b busy=%0b rdy=%0b want 1 1 1", cpu_hold, busy, byte_ready);
    end
    q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h60, 8'hFF, 8'h33, 8'h83, 8'h52, 8'h00};
    send_q(0);
    wait_end("basic");
    check_basic_writes("basic");
  endtask

  task automatic test_zero_count();
    clear_log();
    pulse_start();
    q = '{8'h00, 8'h00};
    send_q(0);
    #2;
    vectors++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_err: got err=%0b hold=%0b done=%0b busy=%0b want 1 1 0 0", err, cpu_hold, done, busy);
    end
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (byte_ready !== 1'b0 || nw !== 0) begin
      miscompares++;
      $display("FAIL zero_no_accept: got rdy=%0b writes=%0d want 0 0", byte_ready, nw);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_count_boundary();
    clear_log();
    pulse_start();
    vectors++;
    if (err !== 1'b0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL bound_start_clears_err: got err=%0b hold=%0b want 0 1", err, cpu_hold);
    end
    q = '{8'h13, 8'h00};
    send_q(0);
    #2;
    vectors++;
    if (err !== 1'b1 || nw !== 0) begin
      miscompares++;
      $display("FAIL bound_19_rejected: got err=%0b writes=%0d want 1 0", err, nw);
    end
    @(negedge clk);
    pulse_start();
    q = '{8'h12, 8'h00};
    for (int i = 0; i < 72; i++) q.push_back(8'(i));
    send_q(0);
    wait_end("bound18");
    vectors++;
    if (nw !== 18 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL bound18_count: got writes=%0d done=%0b want 18 1", nw, done);
    end
    vectors++;
    if (wd[0] !== 32'h03020100) begin
      miscompares++;
      $display("FAIL bound18_first: got %h want 03020100", wd[0]);
    end
    vectors++;
    if (wa[17] !== 32'h44 || wd[17] !== 32'h47464544) begin
      miscompares++;
      $display("FAIL bound18_last: got %h@%h want 47464544@00000044", wd[17], wa[17]);
    end
    vectors++;
    if (lat_bad !== 0 || width_bad !== 0) begin
      miscompares++;
      $display("FAIL bound18_strobe: got late=%0d wide=%0d want 0 0", lat_bad, width_bad);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h60, 8'hFF, 8'h33, 8'h83, 8'h52, 8'h00};
    send_q(5);
    wait_end("gaps");
    check_basic_writes("gaps");
  endtask

  task automatic test_start_ignored();
    clear_log();
    pulse_start();
    q = '{8'h02, 8'h00, 8'h93, 8'h02};
    send_q(0);
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midstart_busy: got busy=%0b rdy=%0b want 1 1", busy, byte_ready);
    end
    q = '{8'h60, 8'hFF, 8'h33, 8'h83, 8'h52, 8'h00};
    send_q(0);
    wait_end("midstart");
    check_basic_writes("midstart");
    clear_log();
    pulse_start();
    vectors++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: got done=%0b err=%0b busy=%0b hold=%0b want 0 0 1 1", done, err, busy, cpu_hold);
    end
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_q(0);
    wait_end("restart");
    vectors++;
    if (nw !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h12345678 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_write: got n=%0d %h@%h done=%0b want 1 12345678@00000000 1", nw, wd[0], wa[0], done);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    q = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h60, 8'hFF, 8'h33, 8'h83};
    send_q(0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, err} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got rdy=%0b we=%0b hold=%0b busy=%0b done=%0b err=%0b addr=%h data=%h want all 0",
               byte_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata);
    end
    vectors++;
    if (nw !== 1 || wd[0] !== 32'hFF600293) begin
      miscompares++;
      $display("FAIL midreset_word0: got n=%0d %h want 1 ff600293", nw, wd[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    prev_we     = 1'b0;
    prev_xfer   = 1'b0;
    clear_log();
    test_reset();
    test_basic();
    test_zero_count();
    test_count_boundary();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
